game_logic: RTL and testbench

Core of the FPGA snake game: holds snake body, food position and length on a 40x30 cell grid. Advances the snake one cell per `mover` strobe in the direction given by `accion`. Detects eating, wall hits and self-collision, and colours each VGA pixel supplied by the 800x600 timing generator. Game-over raises a one-cycle `reset` pulse that re-initialises the game and is shared with the VGA controller and the direction FSM.

---
 rtl/game_logic.sv | 172 +++++++++++++++++
 tb/tb_game_logic.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/game_logic.sv
// Snake game core: snake body, food and length on a cell grid, one-cell
// moves on each step strobe, collision/eat detection and per-pixel colouring.
module game_logic #(
    parameter int CELL     = 20,
    parameter int GRID_W   = 40,
    parameter int GRID_H   = 30,
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic        mover,
    input  logic [10:0] PixelX,
    input  logic [10:0] PixelY,
    input  logic [2:0]  accion,
    output logic [2:0]  RObtenido,
    output logic [2:0]  GObtenido,
    output logic [1:0]  BObtenido,
    output logic        reset
);

    typedef enum logic [2:0] {
        DIR_HOLD  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_e;

    localparam logic [5:0]  X_MAX    = 6'(GRID_W - 1);
    localparam logic [5:0]  X_SPAN   = 6'(GRID_W);
    localparam logic [5:0]  START_X  = 6'(GRID_W / 2);
    localparam logic [5:0]  FOOD_X0  = 6'(GRID_W * 3 / 4);
    localparam logic [4:0]  Y_MAX    = 5'(GRID_H - 1);
    localparam logic [4:0]  Y_SPAN   = 5'(GRID_H);
    localparam logic [4:0]  START_Y  = 5'(GRID_H / 2);
    localparam logic [4:0]  LEN_INIT = 5'(INIT_LEN);
    localparam logic [4:0]  LEN_MAX  = 5'(MAX_LEN);
    localparam logic [10:0] PIX_W    = 11'(GRID_W * CELL);
    localparam logic [10:0] PIX_H    = 11'(GRID_H * CELL);
    // Fixed-point reciprocal of CELL (Q16, rounded up); exact for pixels inside the grid.
    localparam int unsigned RECIP    = (65536 + CELL - 1) / CELL;

    logic [5:0]  seg_x [MAX_LEN];
    logic [4:0]  seg_y [MAX_LEN];
    logic [4:0]  len;
    logic [5:0]  food_x;
    logic [4:0]  food_y;
    logic [15:0] lfsr;

    logic [5:0]  nx, new_fx, cell_x;
    logic [4:0]  ny, new_fy, cell_y;
    logic        dir_ok, wall, hit, eat, step, game_over;
    logic        in_grid, is_head, is_body, is_food;
    logic [2:0]  r_n, g_n;
    logic [1:0]  b_n;

    // Next head position, wall/self collision and eat detection for a step.
    always_comb begin
        nx     = seg_x[0];
        ny     = seg_y[0];
        wall   = 1'b0;
        dir_ok = 1'b1;
        case (accion)
            DIR_UP:    if (seg_y[0] == '0)   wall = 1'b1; else ny = seg_y[0] - 5'd1;
            DIR_DOWN:  if (seg_y[0] == Y_MAX) wall = 1'b1; else ny = seg_y[0] + 5'd1;
            DIR_LEFT:  if (seg_x[0] == '0)   wall = 1'b1; else nx = seg_x[0] - 6'd1;
            DIR_RIGHT: if (seg_x[0] == X_MAX) wall = 1'b1; else nx = seg_x[0] + 6'd1;
            default:   dir_ok = 1'b0;
        endcase
        step = mover && !reset && dir_ok;
        eat  = (nx == food_x) && (ny == food_y);
        hit  = 1'b0;
        // The tail cell only counts when eating, since otherwise it moves away this step.
        for (int unsigned i = 1; i < MAX_LEN; i++) begin
            if (i < 32'(len) && (eat || i != 32'(len) - 1) &&
                seg_x[i] == nx && seg_y[i] == ny)
                hit = 1'b1;
        end
        game_over = step && (wall || hit);
        new_fx = (lfsr[5:0]  >= X_SPAN) ? lfsr[5:0]  - X_SPAN : lfsr[5:0];
        new_fy = (lfsr[12:8] >= Y_SPAN) ? lfsr[12:8] - Y_SPAN : lfsr[12:8];
    end

    // Free-running pseudo-random source; only rst re-seeds it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lfsr <= 16'hACE1;
        else
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    // Game state: initialise on rst or game-over, otherwise advance on a step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reset  <= 1'b0;
            len    <= LEN_INIT;
            food_x <= FOOD_X0;
            food_y <= START_Y;
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= START_X - 6'(i);
                seg_y[i] <= START_Y;
            end
        end else begin
            reset <= game_over;
            if (game_over) begin
                len    <= LEN_INIT;
                food_x <= FOOD_X0;
                food_y <= START_Y;
                for (int unsigned i = 0; i < MAX_LEN; i++) begin
                    seg_x[i] <= START_X - 6'(i);
                    seg_y[i] <= START_Y;
                end
            end else if (step) begin
                for (int unsigned i = 1; i < MAX_LEN; i++) begin
                    seg_x[i] <= seg_x[i-1];
                    seg_y[i] <= seg_y[i-1];
                end
                seg_x[0] <= nx;
                seg_y[0] <= ny;
                if (eat) begin
                    if (len != LEN_MAX)
                        len <= len + 5'd1;
                    food_x <= new_fx;
                    food_y <= new_fy;
                end
            end
        end
    end

    // Pixel classification: cell lookup and colour priority head > body > food > background.
    always_comb begin
        cell_x  = 6'((28'(PixelX) * 28'(RECIP)) >> 16);
        cell_y  = 5'((28'(PixelY) * 28'(RECIP)) >> 16);
        in_grid = (PixelX < PIX_W) && (PixelY < PIX_H);
        is_head = (cell_x == seg_x[0]) && (cell_y == seg_y[0]);
        is_food = (cell_x == food_x) && (cell_y == food_y);
        is_body = 1'b0;
        for (int unsigned i = 1; i < MAX_LEN; i++) begin
            if (i < 32'(len) && cell_x == seg_x[i] && cell_y == seg_y[i])
                is_body = 1'b1;
        end
        r_n = '0;
        g_n = '0;
        b_n = '0;
        if (in_grid) begin
            if (is_head)      g_n = 3'd7;
            else if (is_body) g_n = 3'd4;
            else if (is_food) r_n = 3'd7;
            else              b_n = 2'd1;
        end
    end

    // Registered colour outputs, advanced at pixel rate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RObtenido <= '0;
            GObtenido <= '0;
            BObtenido <= '0;
        end else if (game_over) begin
            RObtenido <= '0;
            GObtenido <= '0;
            BObtenido <= '0;
        end else if (pix_en) begin
            RObtenido <= r_n;
            GObtenido <= g_n;
            BObtenido <= b_n;
        end
    end

endmodule

// File: tb/tb_game_logic.sv
// Directed bench for game_logic: reset state, moves, eating, walls, self-collision.
module tb_game_logic;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pix_en = 1'b0;
    logic        mover = 1'b0;
    logic [10:0] PixelX = '0;
    logic [10:0] PixelY = '0;
    logic [2:0]  accion = '0;
    logic [2:0]  RObtenido, GObtenido;
    logic [1:0]  BObtenido;
    logic        reset;

    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0] m_lfsr;
    logic [15:0] cap_lfsr;
    logic [5:0]  fx;
    logic [4:0]  fy;
    logic        p, exp_go;
    logic [7:0]  exp_c;
    int          hx;

    localparam logic [7:0] C_HEAD = 8'b000_111_00;
    localparam logic [7:0] C_BODY = 8'b000_100_00;
    localparam logic [7:0] C_FOOD = 8'b111_000_00;
    localparam logic [7:0] C_BG   = 8'b000_000_01;
    localparam logic [7:0] C_OFF  = 8'b000_000_00;

    game_logic #(
        .CELL(20), .GRID_W(40), .GRID_H(30), .MAX_LEN(16), .INIT_LEN(3)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .mover(mover),
        .PixelX(PixelX), .PixelY(PixelY), .accion(accion),
        .RObtenido(RObtenido), .GObtenido(GObtenido), .BObtenido(BObtenido),
        .reset(reset)
    );

    always #5 clk = ~clk;
    always @(negedge clk) pix_en = ~pix_en;

    // Reference LFSR: left shift, feedback from taps 16,14,13,11.
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One-clock step strobe; returns the reset output seen one clock later.
    task automatic strobe(input logic [2:0] dir, output logic pulse);
        @(negedge clk);
        accion   = dir;
        mover    = 1'b1;
        cap_lfsr = m_lfsr;
        @(negedge clk);
        mover  = 1'b0;
        accion = '0;
        pulse  = reset;
    endtask

    task automatic render_px(input int px, input int py, input logic [7:0] exp, input string tag);
        @(negedge clk);
        PixelX = 11'(px);
        PixelY = 11'(py);
        repeat (3) @(negedge clk);
        chk(tag, {8'h00, RObtenido, GObtenido, BObtenido}, {8'h00, exp});
    endtask

    task automatic render_cell(input int cx, input int cy, input logic [7:0] exp, input string tag);
        render_px(cx * 20 + 5, cy * 20 + 5, exp, tag);
    endtask

    initial begin
        // 1: reset state
        #2 rst = 1'b1;
        #20;
        chk("rst_reset_low", 16'(reset), 16'd0);
        chk("rst_colour_zero", {8'h00, RObtenido, GObtenido, BObtenido}, 16'h0000);
        @(negedge clk) rst = 1'b0;
        render_px(405, 305, C_HEAD, "init_head");
        render_px(605, 305, C_FOOD, "init_food");
        render_px(900, 305, C_OFF, "offscreen_x");
        render_px(405, 610, C_OFF, "offscreen_y");
        render_cell(19, 15, C_BODY, "init_seg1");
        render_cell(18, 15, C_BODY, "init_seg2");
        render_cell(17, 15, C_BG, "init_bg");

        // 2: single right step, then hold codes
        strobe(3'd4, p);
        chk("step_right_no_reset", 16'(p), 16'd0);
        render_cell(21, 15, C_HEAD, "right_head");
        render_cell(20, 15, C_BODY, "right_seg1");
        render_cell(19, 15, C_BODY, "right_seg2");
        render_cell(18, 15, C_BG, "right_tail_vacated");
        strobe(3'd0, p);
        strobe(3'd6, p);
        chk("hold_no_reset", 16'(p), 16'd0);
        render_cell(21, 15, C_HEAD, "hold_head");

        // 3: nine more right steps, last one eats food at (30,15)
        repeat (9) strobe(3'd4, p);
        chk("eat_no_reset", 16'(p), 16'd0);
        fx = cap_lfsr[5:0];
        if (fx >= 6'd40) fx = fx - 6'd40;
        fy = cap_lfsr[12:8];
        if (fy >= 5'd30) fy = fy - 5'd30;
        render_cell(30, 15, C_HEAD, "eat_head");
        render_cell(27, 15, C_BODY, "grown_seg3");
        exp_c = (fx == 6'd26 && fy == 5'd15) ? C_FOOD : C_BG;
        render_cell(26, 15, exp_c, "grown_beyond_tail");
        if (fy == 5'd15 && fx == 6'd30)                      exp_c = C_HEAD;
        else if (fy == 5'd15 && fx >= 6'd27 && fx <= 6'd29) exp_c = C_BODY;
        else                                                 exp_c = C_FOOD;
        render_cell(int'(fx), int'(fy), exp_c, "food_relocated");

        // Square loop into the vacating tail: legal unless an eat on the way keeps the tail.
        exp_go = (fx == 6'd30 && fy == 5'd14) || (fx == 6'd29 && fy == 5'd14) ||
                 (fx == 6'd29 && fy == 5'd15);
        strobe(3'd1, p);
        chk("loop_up", 16'(p), 16'd0);
        strobe(3'd3, p);
        chk("loop_left", 16'(p), 16'd0);
        strobe(3'd2, p);
        chk("loop_down_into_tail", 16'(p), 16'(exp_go));
        hx = exp_go ? 20 : 29;
        render_cell(hx, 15, C_HEAD, "loop_head");

        // Clean restart for the wall test
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;

        // 4: fifteen up steps reach the top row, the sixteenth hits the wall
        for (int i = 0; i < 15; i++) begin
            strobe(3'd1, p);
            chk("up_no_reset", 16'(p), 16'd0);
        end
        render_cell(20, 0, C_HEAD, "top_row_head");
        render_cell(20, 2, C_BODY, "top_row_seg2");
        @(negedge clk);
        accion = 3'd1;
        mover  = 1'b1;
        @(negedge clk);
        chk("wall_pulse_high", 16'(reset), 16'd1);
        accion = 3'd3;  // would self-collide if not ignored during the pulse
        @(negedge clk);
        mover  = 1'b0;
        accion = '0;
        chk("wall_pulse_one_cycle", 16'(reset), 16'd0);
        @(negedge clk);
        chk("strobe_in_pulse_ignored", 16'(reset), 16'd0);
        render_cell(20, 15, C_HEAD, "wall_reinit_head");
        render_cell(18, 15, C_BODY, "wall_reinit_seg2");
        render_cell(17, 15, C_BG, "wall_reinit_len3");
        render_cell(30, 15, C_FOOD, "wall_reinit_food");
        render_cell(20, 1, C_BG, "wall_old_body_gone");

        // 5: left step into seg[1]
        strobe(3'd3, p);
        chk("self_hit_pulse", 16'(p), 16'd1);
        @(negedge clk);
        chk("self_hit_pulse_end", 16'(reset), 16'd0);
        render_cell(20, 15, C_HEAD, "self_reinit_head");
        render_cell(19, 15, C_BODY, "self_reinit_seg1");

        // 6: grow to length 4, then asynchronous rst between edges
        repeat (10) strobe(3'd4, p);
        render_cell(27, 15, C_BODY, "pre_rst_len4");
        render_cell(30, 15, C_HEAD, "pre_rst_head");
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_colour", {8'h00, RObtenido, GObtenido, BObtenido}, 16'h0000);
        chk("async_rst_no_pulse", 16'(reset), 16'd0);
        @(negedge clk) rst = 1'b0;
        render_cell(20, 15, C_HEAD, "post_rst_head");
        render_cell(27, 15, C_BG, "post_rst_len3");
        render_cell(30, 15, C_FOOD, "post_rst_food");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
